regmap_access_arbiter: RTL and testbench

//  Owns the config/status register bank and shares it between two requesters: port A (SPI slave

---
 rtl/regmap_access_arbiter.sv | 177 +++++++++++++++++
 tb/tb_regmap_access_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regmap_access_arbiter.sv
// Config/status register bank shared by two requesters (A = SPI, B = core).
// Round-robin grant, one access in flight, registered 1-cycle response.
module regmap_access_arbiter #(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CONFIG_REG = 96,
  parameter int NUM_STATUS_REG = 32,
  parameter logic [DATA_WIDTH-1:0] CFG_RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  output logic                  a_rsp_err,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  b_rsp_err,
  output logic [NUM_CONFIG_REG*DATA_WIDTH-1:0] cfg_flat,
  output logic                  busy
);

  localparam int NREG = NUM_CONFIG_REG + NUM_STATUS_REG;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e state_q, state_d;

  // prio_q: 0 = A wins the next tie, 1 = B wins it
  logic prio_q, prio_d;

  logic gnt_a, gnt_b, hs;

  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic in_range, is_cfg, own;
  logic wr_ok, acc_err;
  logic [DATA_WIDTH-1:0] acc_rdata;

  logic [DATA_WIDTH-1:0] regs_q [NREG];
  logic [DATA_WIDTH-1:0] regs_d [NREG];

  logic                  a_vld_q, a_vld_d;
  logic [DATA_WIDTH-1:0] a_rd_q, a_rd_d;
  logic                  a_err_q, a_err_d;
  logic                  b_vld_q, b_vld_d;
  logic [DATA_WIDTH-1:0] b_rd_q, b_rd_d;
  logic                  b_err_q, b_err_d;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == IDLE) begin
      if (a_req_valid && (!b_req_valid || !prio_q)) begin
        gnt_a = 1'b1;
      end else if (b_req_valid) begin
        gnt_b = 1'b1;
      end
    end
  end

  assign hs          = gnt_a | gnt_b;
  assign a_req_ready = gnt_a;
  assign b_req_ready = gnt_b;

  always_comb begin
    req_we    = gnt_b ? b_req_we    : a_req_we;
    req_addr  = gnt_b ? b_req_addr  : a_req_addr;
    req_wdata = gnt_b ? b_req_wdata : a_req_wdata;
  end

  // A owns the config region, B owns the status region
  always_comb begin
    in_range = 32'(req_addr) < 32'(NREG);
    is_cfg   = 32'(req_addr) < 32'(NUM_CONFIG_REG);
    own      = gnt_b ? !is_cfg : is_cfg;
    acc_err  = !in_range || (req_we && !own);
    wr_ok    = hs && req_we && !acc_err;
    if (acc_err) begin
      acc_rdata = '0;
    end else if (req_we) begin
      acc_rdata = req_wdata;
    end else begin
      acc_rdata = regs_q[req_addr];
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[req_addr] = req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = RESP;
          prio_d  = gnt_a;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_vld_d = gnt_a;
    a_rd_d  = gnt_a ? acc_rdata : a_rd_q;
    a_err_d = gnt_a ? acc_err   : a_err_q;
    b_vld_d = gnt_b;
    b_rd_d  = gnt_b ? acc_rdata : b_rd_q;
    b_err_d = gnt_b ? acc_err   : b_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      a_vld_q <= 1'b0;
      a_rd_q  <= '0;
      a_err_q <= 1'b0;
      b_vld_q <= 1'b0;
      b_rd_q  <= '0;
      b_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      a_vld_q <= a_vld_d;
      a_rd_q  <= a_rd_d;
      a_err_q <= a_err_d;
      b_vld_q <= b_vld_d;
      b_rd_q  <= b_rd_d;
      b_err_q <= b_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i < NUM_CONFIG_REG) ? CFG_RESET_VAL : '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_CONFIG_REG; g++) begin : g_cfg
    assign cfg_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  assign a_rsp_valid = a_vld_q;
  assign a_rsp_rdata = a_rd_q;
  assign a_rsp_err   = a_err_q;
  assign b_rsp_valid = b_vld_q;
  assign b_rsp_rdata = b_rd_q;
  assign b_rsp_err   = b_err_q;
  assign busy        = (state_q == RESP);

endmodule

// File: tb/tb_regmap_access_arbiter.sv
// Bench for regmap_access_arbiter: directed and random traffic on both
// ports checked cycle by cycle against a transaction-level model.
module tb_regmap_access_arbiter;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int NCFG  = 96;
  localparam int NSTAT = 31;
  localparam int NREG  = NCFG + NSTAT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_req_valid, a_req_ready, a_req_we;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata, a_rsp_rdata;
  logic a_rsp_valid, a_rsp_err;
  logic b_req_valid, b_req_ready, b_req_we;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata, b_rsp_rdata;
  logic b_rsp_valid, b_rsp_err;
  logic [NCFG*DW-1:0] cfg_flat;
  logic busy;

  always #5 clk = ~clk;

  regmap_access_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_CONFIG_REG(NCFG), .NUM_STATUS_REG(NSTAT),
    .CFG_RESET_VAL(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_req_we(a_req_we), .a_req_addr(a_req_addr),
    .a_req_wdata(a_req_wdata), .a_rsp_valid(a_rsp_valid),
    .a_rsp_rdata(a_rsp_rdata), .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_req_we(b_req_we), .b_req_addr(b_req_addr),
    .b_req_wdata(b_req_wdata), .b_rsp_valid(b_rsp_valid),
    .b_rsp_rdata(b_rsp_rdata), .b_rsp_err(b_rsp_err),
    .cfg_flat(cfg_flat), .busy(busy)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;

  op_t qa[$];
  op_t qb[$];
  int  gnt_log[$];

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] mregs [NREG];
  bit mbusy, mprio, pend_a, pend_b, a_on, b_on;
  logic [DW-1:0] hold_rd_a, hold_rd_b;
  logic hold_err_a, hold_err_b;

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) mregs[i] = 8'h00;
    mbusy = 0; mprio = 0; pend_a = 0; pend_b = 0;
    a_on = 0; b_on = 0;
    hold_rd_a = 8'h00; hold_rd_b = 8'h00;
    hold_err_a = 1'b0; hold_err_b = 1'b0;
  endfunction

  function automatic void model_access(input bit from_b, input op_t op,
                                       output logic [DW-1:0] rd,
                                       output logic err);
    int  a;
    bit  owned;
    a = int'(op.addr);
    owned = from_b ? (a >= NCFG) : (a < NCFG);
    if (a >= NREG || (op.we && !owned)) begin
      rd = 8'h00; err = 1'b1;
    end else if (op.we) begin
      mregs[a] = op.wdata; rd = op.wdata; err = 1'b0;
    end else begin
      rd = mregs[a]; err = 1'b0;
    end
  endfunction

  function automatic logic [NCFG*DW-1:0] cfg_model();
    logic [NCFG*DW-1:0] v;
    for (int i = 0; i < NCFG; i++) v[i*DW +: DW] = mregs[i];
    return v;
  endfunction

  function automatic op_t mk(input logic we, input int addr, input int wd);
    op_t o;
    o.we = we; o.addr = AW'(addr); o.wdata = DW'(wd);
    return o;
  endfunction

  function automatic op_t rand_op();
    return mk(1'($urandom_range(1)), $urandom_range(127), $urandom_range(255));
  endfunction

  task automatic idle_inputs();
    a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic run_traffic(input int arm_pct, input string tag);
    int cyc;
    bit ga, gb;
    cyc = 0;
    while ((qa.size() > 0 || qb.size() > 0 || pend_a || pend_b) && cyc < 3000) begin
      if (!a_on && qa.size() > 0 && $urandom_range(99) < arm_pct) a_on = 1;
      if (!b_on && qb.size() > 0 && $urandom_range(99) < arm_pct) b_on = 1;
      a_req_valid = a_on;
      b_req_valid = b_on;
      if (a_on) begin
        a_req_we = qa[0].we; a_req_addr = qa[0].addr; a_req_wdata = qa[0].wdata;
      end else begin
        a_req_we = 1'($urandom); a_req_addr = AW'($urandom); a_req_wdata = DW'($urandom);
      end
      if (b_on) begin
        b_req_we = qb[0].we; b_req_addr = qb[0].addr; b_req_wdata = qb[0].wdata;
      end else begin
        b_req_we = 1'($urandom); b_req_addr = AW'($urandom); b_req_wdata = DW'($urandom);
      end
      ga = !mbusy && a_on && (!b_on || !mprio);
      gb = !mbusy && b_on && !ga;
      @(negedge clk);
      n_chk++;
      if (a_req_ready !== ga) $display("FAIL %s a_req_ready cyc %0d got %b exp %b", tag, cyc, a_req_ready, ga);
      else n_pass++;
      n_chk++;
      if (b_req_ready !== gb) $display("FAIL %s b_req_ready cyc %0d got %b exp %b", tag, cyc, b_req_ready, gb);
      else n_pass++;
      n_chk++;
      if (busy !== mbusy) $display("FAIL %s busy cyc %0d got %b exp %b", tag, cyc, busy, mbusy);
      else n_pass++;
      n_chk++;
      if (a_rsp_valid !== pend_a) $display("FAIL %s a_rsp_valid cyc %0d got %b exp %b", tag, cyc, a_rsp_valid, pend_a);
      else n_pass++;
      n_chk++;
      if (b_rsp_valid !== pend_b) $display("FAIL %s b_rsp_valid cyc %0d got %b exp %b", tag, cyc, b_rsp_valid, pend_b);
      else n_pass++;
      n_chk++;
      if ({a_rsp_err, a_rsp_rdata} !== {hold_err_a, hold_rd_a})
        $display("FAIL %s a_rsp cyc %0d got err %b rd %h exp err %b rd %h", tag, cyc, a_rsp_err, a_rsp_rdata, hold_err_a, hold_rd_a);
      else n_pass++;
      n_chk++;
      if ({b_rsp_err, b_rsp_rdata} !== {hold_err_b, hold_rd_b})
        $display("FAIL %s b_rsp cyc %0d got err %b rd %h exp err %b rd %h", tag, cyc, b_rsp_err, b_rsp_rdata, hold_err_b, hold_rd_b);
      else n_pass++;
      n_chk++;
      if (cfg_flat !== cfg_model()) $display("FAIL %s cfg_flat cyc %0d differs from model", tag, cyc);
      else n_pass++;
      pend_a = ga;
      pend_b = gb;
      if (ga) begin
        model_access(0, qa[0], hold_rd_a, hold_err_a);
        void'(qa.pop_front());
        a_on = 0;
        gnt_log.push_back(0);
      end
      if (gb) begin
        model_access(1, qb[0], hold_rd_b, hold_err_b);
        void'(qb.pop_front());
        b_on = 0;
        gnt_log.push_back(1);
      end
      mbusy = ga | gb;
      if (ga) mprio = 1;
      else if (gb) mprio = 0;
      @(posedge clk);
      #1 cyc++;
    end
    if (cyc >= 3000) begin
      n_chk++;
      $display("FAIL %s timeout got %0d cycles exp < 3000", tag, cyc);
      qa.delete(); qb.delete();
    end
    a_on = 0; b_on = 0;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, busy} !== 5'b0)
      $display("FAIL reset ctrl got %b exp 00000", {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, busy});
    else n_pass++;
    n_chk++;
    if ({a_rsp_err, b_rsp_err, a_rsp_rdata, b_rsp_rdata} !== 18'h0)
      $display("FAIL reset rsp got %h exp 0", {a_rsp_err, b_rsp_err, a_rsp_rdata, b_rsp_rdata});
    else n_pass++;
    n_chk++;
    if (cfg_flat !== '0) $display("FAIL reset cfg_flat got nonzero exp 0");
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_directed();
    qa.push_back(mk(0, 8'h00, 0));
    qa.push_back(mk(1, 8'h05, 8'hA5));
    qa.push_back(mk(0, 8'h05, 0));
    run_traffic(100, "dir_cfg");
    n_chk++;
    if (cfg_flat[47:40] !== 8'hA5) $display("FAIL dir cfg5 got %h exp a5", cfg_flat[47:40]);
    else n_pass++;
    n_chk++;
    if (a_rsp_rdata !== 8'hA5) $display("FAIL dir rd5 got %h exp a5", a_rsp_rdata);
    else n_pass++;
    qb.push_back(mk(1, 8'h60, 8'h3C));
    run_traffic(100, "dir_stat_wr");
    qa.push_back(mk(0, 8'h60, 0));
    run_traffic(100, "dir_stat_rd");
    n_chk++;
    if (a_rsp_rdata !== 8'h3C) $display("FAIL dir rd60 got %h exp 3c", a_rsp_rdata);
    else n_pass++;
    qa.push_back(mk(1, 8'h60, 8'h11));
    run_traffic(100, "dir_stat_own");
    n_chk++;
    if (a_rsp_err !== 1'b1) $display("FAIL dir a_wr60 err got %b exp 1", a_rsp_err);
    else n_pass++;
    qa.push_back(mk(0, 8'h60, 0));
    qb.push_back(mk(1, 8'h02, 8'hFF));
    run_traffic(100, "dir_cfg_own");
    n_chk++;
    if ({b_rsp_err, a_rsp_rdata} !== {1'b1, 8'h3C})
      $display("FAIL dir own got err %b rd60 %h exp 1 3c", b_rsp_err, a_rsp_rdata);
    else n_pass++;
    n_chk++;
    if (cfg_flat[23:16] !== 8'h00) $display("FAIL dir cfg2 got %h exp 00", cfg_flat[23:16]);
    else n_pass++;
    qa.push_back(mk(0, 8'h7F, 0));
    run_traffic(100, "dir_oor");
    n_chk++;
    if ({a_rsp_err, a_rsp_rdata} !== {1'b1, 8'h00})
      $display("FAIL dir oor got err %b rd %h exp 1 00", a_rsp_err, a_rsp_rdata);
    else n_pass++;
  endtask

  task automatic test_contention();
    reset_dut();
    gnt_log.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(rand_op());
      qb.push_back(rand_op());
    end
    run_traffic(100, "contend");
    n_chk++;
    if (gnt_log.size() != 8) $display("FAIL contend grants got %0d exp 8", gnt_log.size());
    else n_pass++;
    for (int i = 0; i < gnt_log.size(); i++) begin
      n_chk++;
      if (gnt_log[i] != (i % 2)) $display("FAIL contend order %0d got %0d exp %0d", i, gnt_log[i], i % 2);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      qa.push_back(rand_op());
      qb.push_back(rand_op());
    end
    run_traffic(55, "random");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      qa.push_back(mk(1, i, 8'h40 + i));
      qa.push_back(mk(0, i, 0));
      qb.push_back(mk(1, NCFG + i, 8'hC0 + i));
      qb.push_back(mk(0, NCFG + i, 0));
    end
    run_traffic(100, "b2b");
  endtask

  task automatic test_reset_mid();
    bit seen;
    reset_dut();
    a_req_valid = 1; a_req_we = 1; a_req_addr = 7'h10; a_req_wdata = 8'h77;
    @(negedge clk);
    n_chk++;
    if (a_req_ready !== 1'b1) $display("FAIL rstmid ready got %b exp 1", a_req_ready);
    else n_pass++;
    @(posedge clk);
    #1 a_req_valid = 0;
    n_chk++;
    if (cfg_flat[135:128] !== 8'h77) $display("FAIL rstmid wr got %h exp 77", cfg_flat[135:128]);
    else n_pass++;
    rst_n = 0;
    #1 seen = 0;
    n_chk++;
    if ({a_rsp_valid, cfg_flat[135:128]} !== 9'h0)
      $display("FAIL rstmid async got vld %b reg %h exp 0 00", a_rsp_valid, cfg_flat[135:128]);
    else n_pass++;
    repeat (2) @(negedge clk) seen |= a_rsp_valid;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    repeat (3) @(negedge clk) seen |= a_rsp_valid;
    n_chk++;
    if (seen) $display("FAIL rstmid pulse got 1 exp 0");
    else n_pass++;
    @(posedge clk);
    #1 qa.push_back(mk(0, 8'h10, 0));
    run_traffic(100, "rstmid_rd");
    n_chk++;
    if ({a_rsp_err, a_rsp_rdata} !== 9'h0)
      $display("FAIL rstmid rd got err %b rd %h exp 0 00", a_rsp_err, a_rsp_rdata);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_contention();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
